muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Issue sequencer between the execute stage and the iterative multiply/divide unit.
- Accepts RV32M requests with a valid/ready handshake and drives the unit's start, operand and op-select inputs.
- Holds the operands stable for the whole operation and returns the result as a one-cycle valid pulse.
- Handles pipeline flush while an operation is in flight.
- Keeps a one-entry result cache so that a back-to-back identical request completes without re-running the unit.

Parameters:
CACHE_EN, 1, 1 enables the one-entry result cache; 0 forces every request through the unit.
WDOG_CYCLES, 48, maximum cycles from md_start to md_done before a watchdog error is raised.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents an M-extension op
req_ready  out  1  sequencer can accept; high only in IDLE
req_funct3  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  32  rs1 value
req_b  in  32  rs2 value
flush  in  1  pipeline kill; discards any pending request/result
md_start  out  1  one-cycle start pulse to the unit
md_in_A  out  32  operand A to the unit, registered
md_in_B  out  32  operand B to the unit, registered
md_op_mul  out  2  funct3[1:0] when funct3[2]=0, else 0
md_op_div  out  2  funct3[1:0] when funct3[2]=1, else 0
md_sel  out  1  funct3[2] (0 multiply, 1 divide)
md_done  in  1  unit completion
md_R  in  32  unit result, valid while md_done=1
res_valid  out  1  one-cycle pulse, result available
res_data  out  32  result, valid with res_valid
wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset values (all asynchronous on reset=0):
  - state=IDLE.
  - md_start, res_valid and wdog_err are 0.
  - md_in_A, md_in_B, res_data, md_op_mul, md_op_div and md_sel are 0.
  - The cache valid bit is 0 and the kill flag is 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE (req_ready=1):
  - On req_valid & !flush, latch funct3, a and b into the operand registers.
  - Cache hit: cache valid, CACHE_EN=1, funct3/a/b all equal the cached tag. Load res_data from the cache and go to DONE; md_start is never asserted. Latency is req handshake to res_valid = 1 cycle.
  - Miss: go to ISSUE.
  - req_valid & flush in the same cycle: the request is dropped and the state stays IDLE.
- ISSUE:
  - md_start=1 for exactly this cycle; operand and op outputs are already stable.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - md_in_A, md_in_B and the op outputs are held unchanged; the unit reads its inputs in its output stage.
  - The watchdog counter increments each cycle.
  - On md_done: if kill=0, capture md_R into res_data and into the cache (tag=funct3,a,b; valid=1), then go to DONE. If kill=1, discard the result, leave the cache untouched, clear kill, and go to IDLE.
- DONE:
  - res_valid=1 for exactly one cycle, then go to IDLE. The next request is accepted one cycle after res_valid.
- Flush:
  - In ISSUE or WAIT, flush sets kill. The unit cannot be aborted, so the sequencer still waits for md_done. Its result is discarded and no res_valid is produced.
  - flush in DONE does not suppress the already-registered res_valid; the consumer discards it.
  - flush in IDLE has no effect beyond dropping a simultaneous request.
- Watchdog: if the counter reaches WDOG_CYCLES in WAIT:
  - Set wdog_err (sticky until reset).
  - Return res_data=32'hFFFF_FFFF with res_valid, unless kill is set, in which case return silently to IDLE.
  - Do not update the cache, and return to IDLE.
  - A late md_done arriving in IDLE is ignored.
- md_done seen in IDLE, ISSUE or DONE is ignored.
- The cache is pure function memoisation: no invalidation other than reset. Overwrite happens on every non-killed unit completion.
- Counter width is clog2(WDOG_CYCLES+1); it saturates and does not wrap.

Decomposition:
- Shared package:
  - State encoding: 2-bit localparams S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_DONE=3.
  - funct3 constants F3_MUL..F3_REMU.
  - WDOG default.
- One natural sub-module: muldiv_res_cache. It holds the 67-bit tag, 32-bit data and valid bit. It has a lookup port (hit, data) and a write port (we, tag, data), and takes the same clk/reset.

Test Plan:
- MUL a=7,b=6, no flush:
  - Expect md_start exactly 1 cycle after the handshake, with md_sel=0 and md_op_mul=0.
  - With the unit model returning 42, expect res_valid 1 cycle after md_done, res_data=42, and req_ready low throughout.
- DIV a=-20,b=3, then immediately DIV a=-20,b=3 again:
  - The first request runs the unit and returns -6.
  - The second gets res_valid 1 cycle after the handshake, with no md_start pulse.
  - Then REM -20,3 must miss: md_start is pulsed and the result is -2.
- Flush during WAIT on DIVU a=100,b=7:
  - Expect no res_valid, state IDLE the cycle after md_done, and req_ready high again.
  - A following DIVU 100,7 must miss the cache (md_start seen).
- req_valid and flush high together in IDLE: expect no md_start, no res_valid, and req_ready still 1.
- Unit model never asserts md_done: after WDOG_CYCLES in WAIT, expect res_valid with res_data=32'hFFFF_FFFF and wdog_err=1 (staying 1), with the next request accepted normally.
- Assert reset mid-WAIT: all outputs return to their reset values immediately, and the cache misses on a repeat of the last completed op.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the multiply/divide issue sequencer.
package muldiv_seq_pkg;

  // Sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int WDOG_DEFAULT = 48;

  // Cache tag: the full request identity {funct3, a, b}, 67 bits
  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
  } md_tag_t;

  // Op-select field for one half of the unit; zero when the op belongs to the other half
  function automatic logic [1:0] op_field(input logic [2:0] f3, input logic want_div);
    return (f3[2] == want_div) ? f3[1:0] : 2'b00;
  endfunction

endpackage

// File: rtl/muldiv_res_cache.sv
// One-entry memo of the last completed multiply/divide: tag, result and valid bit.
module muldiv_res_cache
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  md_tag_t     lk_tag,
  output logic        lk_hit,
  output logic [31:0] lk_data,
  input  logic        wr_en,
  input  md_tag_t     wr_tag,
  input  logic [31:0] wr_data
);

  md_tag_t     tag_q;
  logic [31:0] data_q;
  logic        valid_q;

  // Entry is overwritten on every write; only reset invalidates it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en) begin
      tag_q   <= wr_tag;
      data_q  <= wr_data;
      valid_q <= 1'b1;
    end
  end

  assign lk_hit  = valid_q && (tag_q == lk_tag);
  assign lk_data = data_q;

endmodule

// File: rtl/muldiv_seq.sv
// Issue sequencer between execute and the iterative multiply/divide unit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | req_ready=1, waiting for a request; cache lookup here
//   S_ISSUE | md_start pulse, operands already stable on md_in_A/B
//   S_WAIT  | operands held, waiting for md_done or watchdog expiry
//   S_DONE  | res_valid pulse, back to IDLE next cycle
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter bit CACHE_EN    = 1'b1,
  parameter int WDOG_CYCLES = WDOG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        md_start,
  output logic [31:0] md_in_A,
  output logic [31:0] md_in_B,
  output logic [1:0]  md_op_mul,
  output logic [1:0]  md_op_div,
  output logic        md_sel,
  input  logic        md_done,
  input  logic [31:0] md_R,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        wdog_err
);

  localparam int            CW      = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] WDOG_TC = CW'(WDOG_CYCLES);

  state_t        state;
  logic [2:0]    f3_q;
  logic          kill_q;
  logic [CW-1:0] wdog_cnt;

  md_tag_t       req_tag;
  md_tag_t       op_tag;
  logic          lk_hit;
  logic          cache_hit;
  logic [31:0]   cache_data;
  logic          cache_we;
  logic          kill_eff;

  assign req_tag   = {req_funct3, req_a, req_b};
  assign op_tag    = {f3_q, md_in_A, md_in_B};
  assign cache_hit = CACHE_EN && lk_hit;

  // A flush arriving in the same cycle as completion/expiry still kills that result
  assign kill_eff  = kill_q | flush;
  assign cache_we  = (state == S_WAIT) && md_done && !kill_eff;

  assign req_ready = (state == S_IDLE);
  assign md_sel    = f3_q[2];
  assign md_op_mul = op_field(f3_q, 1'b0);
  assign md_op_div = op_field(f3_q, 1'b1);

  muldiv_res_cache u_cache (
    .clk     (clk),
    .reset   (reset),
    .lk_tag  (req_tag),
    .lk_hit  (lk_hit),
    .lk_data (cache_data),
    .wr_en   (cache_we),
    .wr_tag  (op_tag),
    .wr_data (md_R)
  );

  // Sequencer FSM with registered handshake, operand and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      f3_q      <= '0;
      md_in_A   <= '0;
      md_in_B   <= '0;
      md_start  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      wdog_err  <= 1'b0;
      kill_q    <= 1'b0;
      wdog_cnt  <= '0;
    end else begin
      md_start  <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            f3_q    <= req_funct3;
            md_in_A <= req_a;
            md_in_B <= req_b;
            kill_q  <= 1'b0;
            if (cache_hit) begin
              res_data  <= cache_data;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              md_start <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wdog_cnt <= '0;
          if (flush) kill_q <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // The unit cannot be aborted: a flush only marks its result for discard
          if (flush) kill_q <= 1'b1;
          if (md_done) begin
            if (kill_eff) begin
              kill_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              res_data  <= md_R;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end else if (wdog_cnt == WDOG_TC) begin
            wdog_err <= 1'b1;
            if (kill_eff) begin
              kill_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              res_data  <= 32'hFFFF_FFFF;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            wdog_cnt <= wdog_cnt + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
